// File: rtl/hazard_md_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core, with mult/div busy sequencing and a stall counter.
// Optional macro HAZ_FWD_EN: enables E/M/W forwarding; when undefined, any producer match on a used operand stalls.
module hazard_md_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic [4:0]  W_wa,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr,
    output logic        md_busy,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic [31:0] stall_cnt
);

    logic [CNT_W-1:0] r_md_cnt;
    logic [31:0]      r_stall_cnt;

    logic w_e_rs, w_m_rs, w_e_rt, w_m_rt;
    logic w_haz_rs, w_haz_rt, w_md_haz, w_md_busy, w_stall;

    // Register 0 is hardwired zero, so it can never be a real dependency.
    assign w_e_rs = (D_rs == E_wa) && (D_rs != 5'd0);
    assign w_m_rs = (D_rs == M_wa) && (D_rs != 5'd0);
    assign w_e_rt = (D_rt == E_wa) && (D_rt != 5'd0);
    assign w_m_rt = (D_rt == M_wa) && (D_rt != 5'd0);

`ifdef HAZ_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic e_hit, input logic m_hit,
                                           input logic w_hit, input logic [1:0] e_tnew,
                                           input logic [1:0] m_tnew);
        // A pending (Tnew>0) match blocks older stages; the stall covers that cycle.
        if (e_hit)      return (e_tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (m_hit) return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (w_hit) return 2'd3;
        else            return 2'd0;
    endfunction

    logic w_w_rs, w_w_rt;
    assign w_w_rs = (D_rs == W_wa) && (D_rs != 5'd0);
    assign w_w_rt = (D_rt == W_wa) && (D_rt != 5'd0);

    assign w_haz_rs = (w_e_rs && (D_tuse_rs < E_tnew)) || (w_m_rs && (D_tuse_rs < M_tnew));
    assign w_haz_rt = (w_e_rt && (D_tuse_rt < E_tnew)) || (w_m_rt && (D_tuse_rt < M_tnew));

    assign fwd_rs_sel = fwd_sel(w_e_rs, w_m_rs, w_w_rs, E_tnew, M_tnew);
    assign fwd_rt_sel = fwd_sel(w_e_rt, w_m_rt, w_w_rt, E_tnew, M_tnew);
`else
    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{W_wa, E_tnew, M_tnew};

    // Without bypass paths every in-flight producer must drain; W relies on regfile write-through.
    assign w_haz_rs = (D_tuse_rs != 2'd3) && (w_e_rs || w_m_rs);
    assign w_haz_rt = (D_tuse_rt != 2'd3) && (w_e_rt || w_m_rt);

    assign fwd_rs_sel = 2'd0;
    assign fwd_rt_sel = 2'd0;
`endif

    assign w_md_busy = (r_md_cnt != '0);
    assign w_md_haz  = D_is_md && (w_md_busy || E_md_start);
    assign w_stall   = w_haz_rs || w_haz_rt || w_md_haz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt    <= '0;
            r_stall_cnt <= 32'd0;
        end else begin
            // A start while busy is dropped; the running count is not disturbed.
            if (E_md_start && !w_md_busy)
                r_md_cnt <= E_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            else if (w_md_busy)
                r_md_cnt <= r_md_cnt - CNT_W'(1);
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall     = w_stall;
    assign F_en      = ~w_stall;
    assign D_en      = ~w_stall;
    assign E_clr     = w_stall;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Scoreboard bench for hazard_md_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_hazard_md_ctrl;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  D_rs = '0, D_rt = '0, E_wa = '0, M_wa = '0, W_wa = '0;
    logic [1:0]  D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, E_tnew = '0, M_tnew = '0;
    logic        D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
    logic        stall, F_en, D_en, E_clr, md_busy;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;

    hazard_md_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew), .W_wa(W_wa),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .stall(stall), .F_en(F_en), .D_en(D_en), .E_clr(E_clr), .md_busy(md_busy),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          stall;
        bit          busy;
        int          frs;   // -1 = don't care
        int          frt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          vec_id  = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string nm, input int id, input longint act, input longint want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", nm, id, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",   e.id, longint'(stall),   longint'(e.stall));
            chk("F_en",    e.id, longint'(F_en),    longint'(!e.stall));
            chk("D_en",    e.id, longint'(D_en),    longint'(!e.stall));
            chk("E_clr",   e.id, longint'(E_clr),   longint'(e.stall));
            chk("md_busy", e.id, longint'(md_busy), longint'(e.busy));
            if (e.frs >= 0) chk("fwd_rs_sel", e.id, longint'(fwd_rs_sel), longint'(e.frs));
            if (e.frt >= 0) chk("fwd_rt_sel", e.id, longint'(fwd_rt_sel), longint'(e.frt));
            chk("stall_cnt", e.id, longint'(stall_cnt), longint'(e.cnt));
        end
    end

    // Drive one cycle of inputs just after the edge and queue the expected response.
    task automatic step(input bit rst, input int rs, input int rt, input int tr, input int tt,
                        input bit md, input int ewa, input int etn, input int mwa, input int mtn,
                        input int wwa, input bit st, input bit dv,
                        input bit x_stall, input bit x_busy, input int x_frs, input int x_frt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; D_rs = 5'(rs); D_rt = 5'(rt); D_tuse_rs = 2'(tr); D_tuse_rt = 2'(tt);
        D_is_md = md; E_wa = 5'(ewa); E_tnew = 2'(etn); M_wa = 5'(mwa); M_tnew = 2'(mtn);
        W_wa = 5'(wwa); E_md_start = st; E_md_div = dv;
        vec_id++;
        e.id = vec_id; e.stall = x_stall; e.busy = x_busy; e.frs = x_frs; e.frt = x_frt;
        e.cnt = exp_cnt;
        q.push_back(e);
        if (rst) exp_cnt = 32'd0;
        else if (x_stall) exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
        $fatal(1);
    end

    initial begin
        //    rst rs rt tr tt md ewa etn mwa mtn wwa st dv | stall busy frs frt
        step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // Mult start, D mult/div stalls on busy, then reset aborts it
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        step(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // Load-use: E pending, then M pending, then M ready
        step(0, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0, 0,   1, 0, FWD ? -1 : 0, 0);
        step(0, 8, 0, 0, 3, 0, 0, 0, 8, 1, 0, 0, 0,   1, 0, FWD ? -1 : 0, 0);
        step(0, 8, 0, 0, 3, 0, 0, 0, 8, 0, 0, 0, 0,   !FWD, 0, FWD ? 2 : 0, 0);
        // ALU chain on rt, then register 0
        step(0, 0, 5, 3, 1, 0, 5, 0, 0, 0, 0, 0, 0,   !FWD, 0, 0, FWD ? 1 : 0);
        step(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0,   0, 0, 0, 0);
        // Priority E > M > W
        step(0, 9, 0, 0, 3, 0, 9, 0, 9, 0, 9, 0, 0,   !FWD, 0, FWD ? 1 : 0, 0);
        step(0, 9, 0, 0, 3, 0, 3, 0, 9, 0, 9, 0, 0,   !FWD, 0, FWD ? 2 : 0, 0);
        step(0, 9, 0, 0, 3, 0, 3, 0, 3, 0, 9, 0, 0,   0, 0, FWD ? 3 : 0, 0);
        // Unused operand never stalls; Tuse == Tnew is not a hazard when forwarding
        step(0, 9, 0, 3, 3, 0, 9, 2, 0, 0, 0, 0, 0,   0, 0, FWD ? -1 : 0, 0);
        step(0, 4, 0, 1, 3, 0, 4, 1, 0, 0, 0, 0, 0,   !FWD, 0, FWD ? -1 : 0, 0);
        // Both operands hazard plus MD hazard: a single stall cycle
        step(0, 8, 8, 0, 0, 1, 8, 2, 0, 0, 0, 1, 0,   1, 0, FWD ? -1 : 0, FWD ? -1 : 0);
        step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        // Div: start cycle plus 10 busy cycles stall; a start while busy is ignored
        step(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, (i == 3), 0,   1, 1, 0, 0);
        step(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // Counter wrap: preload all-ones while a load-use stall is held
        step(0, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0, 0,   1, 0, FWD ? -1 : 0, 0);
        @(negedge clk);
        #1;
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        exp_cnt = 32'd0;
        step(0, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0, 0,   1, 0, FWD ? -1 : 0, 0);
        step(0, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        repeat (2) @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
